// File: rtl/fpu_issue_scoreboard.sv
// Issue controller and register scoreboard for the FP execution units: accepts one
// decoded instruction per cycle, tracks pending writes and schedules the shared writeback port.
module fpu_issue_scoreboard #(
   parameter int PIPE_LATENCY = 4,
   parameter int DIV_LATENCY  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic        issue_div,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rs3,
   input  logic        issue_rd_float,
   input  logic        issue_rs1_float,
   input  logic        issue_rs2_float,
   input  logic        issue_rs3_float,
   input  logic        issue_use_rs2,
   input  logic        issue_use_rs3,
   output logic        pipe_start,
   output logic        div_start,
   output logic        wb_valid,
   output logic        wb_sel,
   output logic [4:0]  wb_rd,
   output logic        wb_rd_float,
   output logic [31:0] busy_int,
   output logic [31:0] busy_float,
   output logic        idle
);

   localparam int CW = $clog2(DIV_LATENCY);
   localparam logic [CW-1:0] DIV_RELOAD = CW'(DIV_LATENCY - 1);
   localparam logic [CW-1:0] PIPE_HIT   = CW'(PIPE_LATENCY);

   logic [31:0]             busy_int_reg;
   logic [31:0]             busy_int_next;
   logic [31:0]             busy_float_reg;
   logic [31:0]             busy_float_next;

   logic                    div_busy_reg;
   logic [CW-1:0]           div_count_reg;
   logic [4:0]              div_rd_reg;
   logic                    div_rd_float_reg;

   logic [PIPE_LATENCY-1:0] pipe_valid;
   logic [PIPE_LATENCY-1:0] pipe_rd_float;
   logic [4:0]              pipe_rd [PIPE_LATENCY];

   logic rs1_busy;
   logic rs2_busy;
   logic rs3_busy;
   logic rd_busy;
   logic hazard;
   logic div_free;
   logic pipe_blocked;
   logic accept;
   logic pipe_accept;
   logic div_accept;
   logic div_wb;
   logic pipe_wb;
   logic wb_fire;

   // Integer x0 reads as never busy regardless of the stored bit.
   function automatic logic reg_busy(input logic [4:0] num, input logic flt,
                                     input logic [31:0] bi, input logic [31:0] bf);
      if (flt)
         return bf[num];
      else if (num == 5'd0)
         return 1'b0;
      else
         return bi[num];
   endfunction

   always_comb begin
      rs1_busy     = reg_busy(issue_rs1, issue_rs1_float, busy_int_reg, busy_float_reg);
      rs2_busy     = issue_use_rs2 && reg_busy(issue_rs2, issue_rs2_float, busy_int_reg, busy_float_reg);
      rs3_busy     = issue_use_rs3 && reg_busy(issue_rs3, issue_rs3_float, busy_int_reg, busy_float_reg);
      rd_busy      = reg_busy(issue_rd, issue_rd_float, busy_int_reg, busy_float_reg);
      hazard       = rs1_busy || rs2_busy || rs3_busy || rd_busy;
      // A divider writing back this cycle can take a new op immediately.
      div_free     = !div_busy_reg || (div_count_reg == '0);
      // A pipe op issued now would land on the same cycle as the pending divide result.
      pipe_blocked = div_busy_reg && (div_count_reg == PIPE_HIT);
      issue_ready  = !reset && !hazard && (issue_div ? div_free : !pipe_blocked);
      accept       = issue_valid && issue_ready;
      pipe_accept  = accept && !issue_div;
      div_accept   = accept && issue_div;
   end

   assign pipe_start = pipe_accept;
   assign div_start  = div_accept;

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LATENCY; gi++) begin : g_stage
         logic       valid_in;
         logic       float_in;
         logic [4:0] rd_in;
         logic       valid_reg;
         logic       float_reg;
         logic [4:0] rd_reg;

         if (gi == 0) begin : g_head
            assign valid_in = pipe_accept;
            assign float_in = issue_rd_float;
            assign rd_in    = issue_rd;
         end else begin : g_link
            assign valid_in = pipe_valid[gi-1];
            assign float_in = pipe_rd_float[gi-1];
            assign rd_in    = pipe_rd[gi-1];
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               valid_reg <= 1'b0;
               float_reg <= 1'b0;
               rd_reg    <= 5'd0;
            end else begin
               valid_reg <= valid_in;
               float_reg <= float_in;
               rd_reg    <= rd_in;
            end
         end

         assign pipe_valid[gi]    = valid_reg;
         assign pipe_rd_float[gi] = float_reg;
         assign pipe_rd[gi]       = rd_reg;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         div_busy_reg     <= 1'b0;
         div_count_reg    <= '0;
         div_rd_reg       <= 5'd0;
         div_rd_float_reg <= 1'b0;
      end else if (div_accept) begin
         div_busy_reg     <= 1'b1;
         div_count_reg    <= DIV_RELOAD;
         div_rd_reg       <= issue_rd;
         div_rd_float_reg <= issue_rd_float;
      end else if (div_busy_reg) begin
         if (div_count_reg == '0)
            div_busy_reg <= 1'b0;
         else
            div_count_reg <= div_count_reg - CW'(1);
      end
   end

   // The divide result always owns the port; issue blocking guarantees no overlap.
   always_comb begin
      div_wb      = div_busy_reg && (div_count_reg == '0);
      pipe_wb     = pipe_valid[PIPE_LATENCY-1];
      wb_fire     = !reset && (div_wb || pipe_wb);
      wb_valid    = wb_fire;
      wb_sel      = 1'b0;
      wb_rd       = 5'd0;
      wb_rd_float = 1'b0;
      if (div_wb) begin
         wb_sel      = 1'b1;
         wb_rd       = div_rd_reg;
         wb_rd_float = div_rd_float_reg;
      end else if (pipe_wb) begin
         wb_rd       = pipe_rd[PIPE_LATENCY-1];
         wb_rd_float = pipe_rd_float[PIPE_LATENCY-1];
      end
   end

   always_comb begin
      busy_int_next   = busy_int_reg;
      busy_float_next = busy_float_reg;
      if (wb_fire) begin
         if (wb_rd_float)
            busy_float_next[wb_rd] = 1'b0;
         else
            busy_int_next[wb_rd] = 1'b0;
      end
      if (accept) begin
         if (issue_rd_float)
            busy_float_next[issue_rd] = 1'b1;
         else
            busy_int_next[issue_rd] = 1'b1;
      end
      busy_int_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_int_reg   <= 32'd0;
         busy_float_reg <= 32'd0;
      end else begin
         busy_int_reg   <= busy_int_next;
         busy_float_reg <= busy_float_next;
      end
   end

   assign busy_int   = busy_int_reg;
   assign busy_float = busy_float_reg;
   assign idle       = (busy_int_reg == 32'd0) && (busy_float_reg == 32'd0) &&
                       (pipe_valid == '0) && !div_busy_reg;

endmodule
